// File: rtl/dcache_controller.sv
// dcache_controller: 16-line x 1-word direct-mapped, write-back, write-allocate data cache controller.
// Revision 1.0
`default_nettype none

module dcache_controller (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_data_i,
  input  logic        p1_MemRead_i,
  input  logic        p1_MemWrite_i,
  output logic [31:0] p1_data_o,
  output logic        p1_stall_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        mem_enable_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] valid_q, dirty_q;
  logic [25:0] tag_q  [16];
  logic [31:0] data_q [16];
  logic [3:0]  miss_idx_q, miss_idx_d;
  logic [25:0] miss_tag_q, miss_tag_d;

  logic [3:0]  req_idx;
  logic [25:0] req_tag;
  logic        req, hit, store_we, fill_we;
  logic        unused_addr_bits;

  assign req_idx          = p1_addr_i[5:2];
  assign req_tag          = p1_addr_i[31:6];
  assign unused_addr_bits = ^p1_addr_i[1:0];
  assign req              = p1_MemRead_i | p1_MemWrite_i;
  assign hit              = req & valid_q[req_idx] & (tag_q[req_idx] == req_tag);

  assign p1_stall_o = (state_q != IDLE) | (req & ~hit);
  assign p1_data_o  = ((state_q == IDLE) && hit && p1_MemRead_i) ? data_q[req_idx] : 32'h0;

  always_comb begin
    state_d      = state_q;
    miss_idx_d   = miss_idx_q;
    miss_tag_d   = miss_tag_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'h0;
    mem_data_o   = 32'h0;
    store_we     = 1'b0;
    fill_we      = 1'b0;
    case (state_q)
      IDLE: begin
        store_we = hit & p1_MemWrite_i;
        // Latch the miss address so the transfer survives req dropping mid-miss.
        if (req && !hit) begin
          miss_idx_d = req_idx;
          miss_tag_d = req_tag;
          state_d    = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[miss_idx_q], miss_idx_q, 2'b00};
        mem_data_o   = data_q[miss_idx_q];
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {miss_tag_q, miss_idx_q, 2'b00};
        if (mem_ack_i) begin
          fill_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      valid_q    <= 16'h0;
      dirty_q    <= 16'h0;
      miss_idx_q <= 4'h0;
      miss_tag_q <= 26'h0;
    end else begin
      state_q    <= state_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
      if (store_we) dirty_q[req_idx] <= 1'b1;
      if (fill_we) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (store_we) data_q[req_idx] <= p1_data_i;
      if (fill_we) begin
        data_q[miss_idx_q] <= mem_data_i;
        tag_q[miss_idx_q]  <= miss_tag_q;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed scoreboard bench with a latency-programmable backing-memory model.
// Revision 1.0
`default_nettype none

module tb_dcache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, mem_rdata;
  logic        rd, wr, ack_r, ack_x;
  logic [31:0] p1_data_o, mem_addr_o, mem_data_o;
  logic        p1_stall_o, mem_enable_o, mem_write_o;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .p1_addr_i    (addr),
    .p1_data_i    (wdata),
    .p1_MemRead_i (rd),
    .p1_MemWrite_i(wr),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_data_i   (mem_rdata),
    .mem_ack_i    (ack_r | ack_x)
  );

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } mem_t;

  int          total = 0;
  int          bad   = 0;
  int          lat   = 1;
  mem_t        mem_exp[$];
  logic [31:0] load_exp[$];
  logic [31:0] bmem [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string name);
    check(name, p1_data_o | mem_addr_o | mem_data_o |
          {29'h0, p1_stall_o, mem_enable_o, mem_write_o}, 32'h0);
  endtask

  // Load-side monitor: every unstalled load presents data that must match the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rd && !p1_stall_o) begin
        if (load_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_load: got %h expected none", p1_data_o);
        end else begin
          check("load_data", p1_data_o, load_exp.pop_front());
        end
      end
    end
  end

  // Backing memory: acks after lat cycles of mem_enable_o and checks each transfer.
  initial begin
    int   cnt;
    mem_t e;
    cnt       = 0;
    ack_r     = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (ack_r) begin
        ack_r = 1'b0;
        cnt   = 0;
      end
      if (rst || !mem_enable_o) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == lat) begin
          ack_r = 1'b1;
          if (mem_exp.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_mem_req: got addr %h expected none", mem_addr_o);
          end else begin
            e = mem_exp.pop_front();
            check("mem_write", {31'h0, mem_write_o}, {31'h0, e.w});
            check("mem_addr", mem_addr_o, e.a);
            if (e.w) check("mem_wdata", mem_data_o, e.d);
          end
          if (mem_write_o) bmem[mem_addr_o[9:2]] = mem_data_o;
          else             mem_rdata = bmem[mem_addr_o[9:2]];
        end
      end
    end
  end

  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int exp_stall);
    int n;
    n = 0;
    @(posedge clk); #1;
    rd = r; wr = w; addr = a; wdata = d;
    @(negedge clk);
    while (p1_stall_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (p1_stall_o) begin
      total++; bad++;
      $display("FAIL stall_timeout: got stall after %0d cycles expected release", n);
    end
    check("stall_cycles", 32'(n), 32'(exp_stall));
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0; ack_x = 1'b0;
    for (int i = 0; i < 256; i++) bmem[i] = 32'h0;
    bmem[8'h10] = 32'hDEAD_BEEF;
    bmem[8'h20] = 32'hCAFE_F00D;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset_outputs");

    // Cold load: ALLOCATE at 0x40, ack latency 3 -> 4 stall cycles.
    lat = 3;
    mem_exp.push_back({1'b0, 32'h40, 32'h0});
    load_exp.push_back(32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h40, 32'h0, 4);

    // Store hit then load hit, no memory traffic.
    access(1'b0, 1'b1, 32'h40, 32'h1234_5678, 0);
    load_exp.push_back(32'h1234_5678);
    access(1'b1, 1'b0, 32'h40, 32'h0, 0);

    // Dirty conflict miss: writeback 0x40 then allocate 0x80.
    lat = 2;
    mem_exp.push_back({1'b1, 32'h40, 32'h1234_5678});
    mem_exp.push_back({1'b0, 32'h80, 32'h0});
    load_exp.push_back(32'hCAFE_F00D);
    access(1'b1, 1'b0, 32'h80, 32'h0, 5);

    // Read+write together: old data shown, line updated and dirtied.
    load_exp.push_back(32'hCAFE_F00D);
    access(1'b1, 1'b1, 32'h80, 32'h55AA_55AA, 0);
    load_exp.push_back(32'h55AA_55AA);
    access(1'b1, 1'b0, 32'h80, 32'h0, 0);
    lat = 1;
    mem_exp.push_back({1'b1, 32'h80, 32'h55AA_55AA});
    mem_exp.push_back({1'b0, 32'h40, 32'h0});
    load_exp.push_back(32'h1234_5678);
    access(1'b1, 1'b0, 32'h40, 32'h0, 3);

    // Store miss allocates first, then writes.
    lat = 2;
    mem_exp.push_back({1'b0, 32'h104, 32'h0});
    access(1'b0, 1'b1, 32'h104, 32'h0BAD_F00D, 3);
    load_exp.push_back(32'h0BAD_F00D);
    access(1'b1, 1'b0, 32'h104, 32'h0, 0);

    // Stray ack in IDLE is ignored.
    @(posedge clk); #1 ack_x = 1'b1;
    @(posedge clk); #1 ack_x = 1'b0;
    @(negedge clk);
    check_idle("idle_ack_ignored");
    load_exp.push_back(32'h0BAD_F00D);
    access(1'b1, 1'b0, 32'h104, 32'h0, 0);

    // Reset during ALLOCATE abandons the transfer and clears valid/dirty.
    lat = 1000;
    @(posedge clk); #1 rd = 1'b1; addr = 32'h200;
    @(negedge clk);
    check("miss_stall", {31'h0, p1_stall_o}, 32'h1);
    @(negedge clk);
    check("alloc_enable", {31'h0, mem_enable_o}, 32'h1);
    check("alloc_addr", mem_addr_o, 32'h200);
    check("alloc_is_read", {31'h0, mem_write_o}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rd = 1'b0;
    @(negedge clk);
    check_idle("reset_abandon");
    @(posedge clk); #1 rst = 1'b0;
    lat = 2;
    mem_exp.push_back({1'b0, 32'h40, 32'h0});
    load_exp.push_back(32'h1234_5678);
    access(1'b1, 1'b0, 32'h40, 32'h0, 3);
    lat = 1;
    mem_exp.push_back({1'b0, 32'h104, 32'h0});
    load_exp.push_back(32'h0);
    access(1'b1, 1'b0, 32'h104, 32'h0, 2);

    repeat (3) @(negedge clk);
    check("load_queue_left", 32'(load_exp.size()), 32'h0);
    check("mem_queue_left", 32'(mem_exp.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
